// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with freeze/flush, illegal-control sanitising and a sticky error flag.
// Optional ID_EX_PERF_CNT_EN adds saturating stall/bubble counters.
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_wb_enable,
  input  logic [3:0]            id_alu_command,
  input  logic [1:0]            id_branch,
  input  logic [PC_W-1:0]       id_pc,
  input  logic [DATA_W-1:0]     id_val1,
  input  logic [DATA_W-1:0]     id_val2,
  input  logic [DATA_W-1:0]     id_st_val,
  input  logic [REG_ADDR_W-1:0] id_dest,
  output logic                  ex_valid,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_wb_enable,
  output logic [3:0]            ex_alu_command,
  output logic [1:0]            ex_branch,
  output logic [PC_W-1:0]       ex_pc,
  output logic [DATA_W-1:0]     ex_val1,
  output logic [DATA_W-1:0]     ex_val2,
  output logic [DATA_W-1:0]     ex_st_val,
  output logic [REG_ADDR_W-1:0] ex_dest,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt,
`endif
  output logic                  err_ctrl
);

  logic                  r_valid;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_wb_enable;
  logic [3:0]            r_alu_command;
  logic [1:0]            r_branch;
  logic [PC_W-1:0]       r_pc;
  logic [DATA_W-1:0]     r_val1;
  logic [DATA_W-1:0]     r_val2;
  logic [DATA_W-1:0]     r_st_val;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_err_ctrl;

  logic w_illegal;
  logic w_load_bubble;
  logic w_load_real;

  // Illegal bundles never reach EX, so a load+store pair cannot appear at the outputs.
  assign w_illegal     = id_valid & ((id_mem_read & id_mem_write) |
                                     ((id_branch != 2'b00) & id_wb_enable));
  assign w_load_bubble = flush | (~freeze & (~id_valid | w_illegal));
  assign w_load_real   = ~flush & ~freeze & id_valid & ~w_illegal;

  always_ff @(posedge clk) begin
    if (rst || (w_load_bubble && !rst)) begin
      r_valid       <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_wb_enable   <= 1'b0;
      r_alu_command <= '0;
      r_branch      <= '0;
      r_pc          <= '0;
      r_val1        <= '0;
      r_val2        <= '0;
      r_st_val      <= '0;
      r_dest        <= '0;
    end else if (w_load_real) begin
      r_valid       <= 1'b1;
      r_mem_read    <= id_mem_read;
      r_mem_write   <= id_mem_write;
      r_wb_enable   <= id_wb_enable;
      r_alu_command <= id_alu_command;
      r_branch      <= id_branch;
      r_pc          <= id_pc;
      r_val1        <= id_val1;
      r_val2        <= id_val2;
      r_st_val      <= id_st_val;
      r_dest        <= id_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ctrl <= 1'b0;
    end else if (!flush && !freeze && w_illegal) begin
      r_err_ctrl <= 1'b1;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (freeze && !flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_load_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  assign ex_valid       = r_valid;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_wb_enable   = r_wb_enable;
  assign ex_alu_command = r_alu_command;
  assign ex_branch      = r_branch;
  assign ex_pc          = r_pc;
  assign ex_val1        = r_val1;
  assign ex_val2        = r_val2;
  assign ex_st_val      = r_st_val;
  assign ex_dest        = r_dest;
  assign err_ctrl       = r_err_ctrl;

endmodule
